pc_seq_ctrl: RTL and testbench

- Pipeline sequencing controller in front of the PC register.
- Arbitrates redirect and stall sources (EX jump, EX multi-cycle stall, bus wait, debug halt/resume) into one registered jump/hold command for the PC register.
- Generates flush and stall strobes for the IF/ID stages.
- Owns the debug halt handshake and a post-jump flush window.

---
 rtl/pc_seq_ctrl_pkg.sv | 25 ++
 rtl/pc_seq_ctrl_cnt.sv | 32 +++
 rtl/pc_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_ctrl_pkg.sv
// pc_seq_ctrl_pkg: shared definitions for the PC sequencing controller.
//   seq_state_e          - controller state encodings
//   Jump/Hold/Halt flags - named enable/disable levels for the command flags
//   ZeroWord             - all-zero bus word
package pc_seq_ctrl_pkg;

  localparam int unsigned RegBusW = 32;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    FLUSH     = 2'd1,
    HALT_PEND = 2'd2,
    HALTED    = 2'd3
  } seq_state_e;

  localparam logic JumpEnable  = 1'b1;
  localparam logic JumpDisable = 1'b0;
  localparam logic HoldEnable  = 1'b1;
  localparam logic HoldDisable = 1'b0;
  localparam logic HaltEnable  = 1'b1;
  localparam logic HaltDisable = 1'b0;

  localparam logic [RegBusW-1:0] ZeroWord = '0;

endpackage

// File: rtl/pc_seq_ctrl_cnt.sv
// pc_seq_cnt: loadable down-counter, saturating at zero.
//   clk, rst  - clock, synchronous active-high reset (count -> 0)
//   load      - load load_val (has priority over dec)
//   load_val  - value to load
//   dec       - decrement by one, holds at zero
//   cnt       - current count
//   zero      - count is zero
module pc_seq_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: pipeline sequencing controller in front of the PC register.
// Arbitrates EX jump, EX stall, bus wait and debug halt/resume into one
// registered jump/hold command, plus IF/ID flush/stall strobes and the
// debug halt acknowledge. All outputs are registered (1-cycle latency).
//   clk, rst                      - clock, synchronous active-high reset
//   pc_i                          - current PC
//   jump_req_i, jump_addr_i       - EX redirect request and target
//   stall_ex_i, stall_ex_addr_i   - EX multi-cycle busy and PC to hold
//   stall_bus_i                   - instruction bus not ready
//   halt_req_i, resume_req_i      - debug halt (level) / resume (pulse)
//   jump_flag_o, jump_addr_o      - redirect command to the PC register
//   hold_flag_o, hold_addr_o      - hold command to the PC register
//   flush_o, stall_o              - IF/ID kill / freeze
//   halted_o                      - debug halt acknowledge
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned DRAIN_MAX    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_req_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              stall_ex_i,
  input  logic [ADDR_W-1:0] stall_ex_addr_i,
  input  logic              stall_bus_i,
  input  logic              halt_req_i,
  input  logic              resume_req_i,
  output logic              jump_flag_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              hold_flag_o,
  output logic [ADDR_W-1:0] hold_addr_o,
  output logic              flush_o,
  output logic              stall_o,
  output logic              halted_o
);

  localparam logic [ADDR_W-1:0] AddrZero  = ADDR_W'(ZeroWord);
  localparam logic [2:0]        FlushInit = 3'(FLUSH_CYCLES);
  localparam logic [3:0]        DrainInit = 4'(DRAIN_MAX);

  seq_state_e        state, state_nxt;
  logic [ADDR_W-1:0] halt_pc, halt_pc_nxt;

  logic              jump_flag_nxt, hold_flag_nxt, flush_nxt, stall_nxt, halted_nxt;
  logic [ADDR_W-1:0] jump_addr_nxt, hold_addr_nxt;

  logic       flush_load, flush_dec, flush_zero;
  logic       drain_load, drain_dec, drain_zero;
  logic [2:0] flush_cnt;
  logic [3:0] drain_cnt;
  logic       flush_last, drain_last;

  pc_seq_cnt #(.W(3)) u_flush_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (flush_load),
    .load_val (FlushInit),
    .dec      (flush_dec),
    .cnt      (flush_cnt),
    .zero     (flush_zero)
  );

  pc_seq_cnt #(.W(4)) u_drain_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (drain_load),
    .load_val (DrainInit),
    .dec      (drain_dec),
    .cnt      (drain_cnt),
    .zero     (drain_zero)
  );

  // Last cycle of the window: counter is about to reach (or sits at) zero.
  assign flush_last = flush_zero || (flush_cnt == 3'd1);
  assign drain_last = drain_zero || (drain_cnt == 4'd1);

  always_comb begin
    state_nxt     = state;
    halt_pc_nxt   = halt_pc;
    jump_flag_nxt = JumpDisable;
    jump_addr_nxt = AddrZero;
    hold_flag_nxt = HoldDisable;
    hold_addr_nxt = AddrZero;
    flush_nxt     = 1'b0;
    stall_nxt     = 1'b0;
    halted_nxt    = HaltDisable;
    flush_load    = 1'b0;
    flush_dec     = 1'b0;
    drain_load    = 1'b0;
    drain_dec     = 1'b0;

    case (state)
      RUN, FLUSH: begin
        if (jump_req_i) begin
          jump_flag_nxt = JumpEnable;
          jump_addr_nxt = jump_addr_i;
          flush_nxt     = 1'b1;
          flush_load    = 1'b1;
          state_nxt     = FLUSH;
        end else if ((state == FLUSH) && !flush_last) begin
          // Flush dominates: stall inputs are not looked at here.
          flush_nxt = 1'b1;
          flush_dec = 1'b1;
        end else if (halt_req_i) begin
          // PC is captured here and held for the whole halt.
          state_nxt     = HALT_PEND;
          drain_load    = 1'b1;
          halt_pc_nxt   = pc_i;
          hold_flag_nxt = HoldEnable;
          hold_addr_nxt = pc_i;
        end else if (state == FLUSH) begin
          state_nxt = RUN;
        end else if (stall_ex_i) begin
          hold_flag_nxt = HoldEnable;
          hold_addr_nxt = stall_ex_addr_i;
          stall_nxt     = 1'b1;
        end else if (stall_bus_i) begin
          hold_flag_nxt = HoldEnable;
          hold_addr_nxt = pc_i;
          stall_nxt     = 1'b1;
        end
      end

      HALT_PEND: begin
        if (jump_req_i) begin
          // Redirect replaces the halt PC; the hold resumes there next cycle.
          jump_flag_nxt = JumpEnable;
          jump_addr_nxt = jump_addr_i;
          halt_pc_nxt   = jump_addr_i;
          drain_load    = 1'b1;
        end else if (!halt_req_i) begin
          state_nxt = RUN;
        end else if ((!stall_ex_i && !stall_bus_i) || drain_last) begin
          state_nxt     = HALTED;
          halted_nxt    = HaltEnable;
          hold_flag_nxt = HoldEnable;
          hold_addr_nxt = halt_pc;
          stall_nxt     = 1'b1;
        end else begin
          hold_flag_nxt = HoldEnable;
          hold_addr_nxt = halt_pc;
          drain_dec     = 1'b1;
        end
      end

      HALTED: begin
        // Resume goes through RUN, so a still-asserted halt re-enters HALT_PEND.
        if (resume_req_i) begin
          state_nxt = RUN;
        end else begin
          halted_nxt    = HaltEnable;
          hold_flag_nxt = HoldEnable;
          hold_addr_nxt = halt_pc;
          stall_nxt     = 1'b1;
        end
      end

      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      halt_pc     <= AddrZero;
      jump_flag_o <= JumpDisable;
      jump_addr_o <= AddrZero;
      hold_flag_o <= HoldDisable;
      hold_addr_o <= AddrZero;
      flush_o     <= 1'b0;
      stall_o     <= 1'b0;
      halted_o    <= HaltDisable;
    end else begin
      state       <= state_nxt;
      halt_pc     <= halt_pc_nxt;
      jump_flag_o <= jump_flag_nxt;
      jump_addr_o <= jump_addr_nxt;
      hold_flag_o <= hold_flag_nxt;
      hold_addr_o <= hold_addr_nxt;
      flush_o     <= flush_nxt;
      stall_o     <= stall_nxt;
      halted_o    <= halted_nxt;
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: self-checking bench for pc_seq_ctrl.
// Each scenario lists (stimulus, expected next-cycle outputs) pairs; the
// expectation enters a scoreboard queue when the stimulus is driven and is
// popped and compared one clock later.
module tb_pc_seq_ctrl;

  typedef struct packed {
    logic        rst;
    logic [31:0] pc;
    logic        jump_req;
    logic [31:0] jump_addr;
    logic        stall_ex;
    logic [31:0] stall_ex_addr;
    logic        stall_bus;
    logic        halt_req;
    logic        resume_req;
  } in_t;

  typedef struct packed {
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        hold_flag;
    logic [31:0] hold_addr;
    logic        flush;
    logic        stall;
    logic        halted;
  } out_t;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, jump_addr_i, stall_ex_addr_i;
  logic        jump_req_i, stall_ex_i, stall_bus_i, halt_req_i, resume_req_i;
  logic        jump_flag_o, hold_flag_o, flush_o, stall_o, halted_o;
  logic [31:0] jump_addr_o, hold_addr_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  in_t  stim_q[$];
  out_t plan_q[$];
  out_t exp_q[$];

  pc_seq_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2), .DRAIN_MAX(15)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_i            (pc_i),
    .jump_req_i      (jump_req_i),
    .jump_addr_i     (jump_addr_i),
    .stall_ex_i      (stall_ex_i),
    .stall_ex_addr_i (stall_ex_addr_i),
    .stall_bus_i     (stall_bus_i),
    .halt_req_i      (halt_req_i),
    .resume_req_i    (resume_req_i),
    .jump_flag_o     (jump_flag_o),
    .jump_addr_o     (jump_addr_o),
    .hold_flag_o     (hold_flag_o),
    .hold_addr_o     (hold_addr_o),
    .flush_o         (flush_o),
    .stall_o         (stall_o),
    .halted_o        (halted_o)
  );

  always #5 clk = ~clk;

  function automatic in_t mki(logic r, logic [31:0] pc, logic jr, logic [31:0] ja,
                              logic sx, logic [31:0] sxa, logic sb, logic hr, logic rr);
    in_t s;
    s.rst = r; s.pc = pc; s.jump_req = jr; s.jump_addr = ja; s.stall_ex = sx;
    s.stall_ex_addr = sxa; s.stall_bus = sb; s.halt_req = hr; s.resume_req = rr;
    return s;
  endfunction

  function automatic out_t mko(logic jf, logic [31:0] ja, logic hf, logic [31:0] ha,
                               logic fl, logic st, logic hl);
    out_t o;
    o.jump_flag = jf; o.jump_addr = ja; o.hold_flag = hf; o.hold_addr = ha;
    o.flush = fl; o.stall = st; o.halted = hl;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.jump_flag = jump_flag_o; o.jump_addr = jump_addr_o;
    o.hold_flag = hold_flag_o; o.hold_addr = hold_addr_o;
    o.flush = flush_o; o.stall = stall_o; o.halted = halted_o;
    return o;
  endfunction

  task automatic drive(input in_t s, input out_t e);
    rst = s.rst; pc_i = s.pc; jump_req_i = s.jump_req; jump_addr_i = s.jump_addr;
    stall_ex_i = s.stall_ex; stall_ex_addr_i = s.stall_ex_addr;
    stall_bus_i = s.stall_bus; halt_req_i = s.halt_req; resume_req_i = s.resume_req;
    exp_q.push_back(e);
  endtask

  task automatic add(input in_t s, input out_t e);
    stim_q.push_back(s);
    plan_q.push_back(e);
  endtask

  function automatic in_t idle();
    return mki(L, 32'h0, L, 32'h0, L, 32'h0, L, L, L);
  endfunction

  function automatic out_t zero_out();
    return mko(L, 32'h0, L, 32'h0, L, L, L);
  endfunction

  task automatic test_reset();
    out_t e, o;
    stim_q.delete(); plan_q.delete();
    for (int i = 0; i < 3; i++)
      add(mki(H, 32'h10, H, 32'h20, H, 32'h30, H, H, H), zero_out());
    add(idle(), zero_out());
    for (int i = 0; i < stim_q.size(); i++) begin
      drive(stim_q[i], plan_q[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_jump();
    out_t e, o;
    stim_q.delete(); plan_q.delete();
    add(mki(L, 32'h0C, H, 32'h100, L, 0, L, L, L), mko(H, 32'h100, L, 0, H, L, L));
    add(idle(),                                    mko(L, 0, L, 0, H, L, L));
    add(idle(),                                    zero_out());
    add(mki(L, 32'h50, L, 0, L, 0, H, L, L),       mko(L, 0, H, 32'h50, L, H, L));
    add(idle(),                                    zero_out());
    for (int i = 0; i < stim_q.size(); i++) begin
      drive(stim_q[i], plan_q[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL jump[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_t e, o;
    stim_q.delete(); plan_q.delete();
    add(mki(L, 0, H, 32'h100, L, 0, L, L, L),           mko(H, 32'h100, L, 0, H, L, L));
    add(mki(L, 0, H, 32'h200, L, 0, L, L, L),           mko(H, 32'h200, L, 0, H, L, L));
    add(mki(L, 32'h44, L, 0, H, 32'h40, H, L, L),       mko(L, 0, L, 0, H, L, L));
    add(idle(),                                         zero_out());
    add(idle(),                                         zero_out());
    // halt raised during a flush waits for the window to close
    add(mki(L, 0, H, 32'h700, L, 0, L, L, L),           mko(H, 32'h700, L, 0, H, L, L));
    add(mki(L, 32'hD0, L, 0, L, 0, L, H, L),            mko(L, 0, L, 0, H, L, L));
    add(mki(L, 32'hD4, L, 0, L, 0, L, H, L),            mko(L, 0, H, 32'hD4, L, L, L));
    add(mki(L, 32'hD8, L, 0, L, 0, L, H, L),            mko(L, 0, H, 32'hD4, L, H, H));
    add(mki(L, 32'hD8, L, 0, L, 0, L, L, H),            zero_out());
    add(idle(),                                         zero_out());
    for (int i = 0; i < stim_q.size(); i++) begin
      drive(stim_q[i], plan_q[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_stall_priority();
    out_t e, o;
    stim_q.delete(); plan_q.delete();
    add(mki(L, 32'h44, L, 0, H, 32'h40, H, L, L),       mko(L, 0, H, 32'h40, L, H, L));
    add(mki(L, 32'h44, L, 0, L, 32'h40, H, L, L),       mko(L, 0, H, 32'h44, L, H, L));
    add(idle(),                                         zero_out());
    add(mki(L, 32'h44, H, 32'h300, H, 32'h40, H, L, L), mko(H, 32'h300, L, 0, H, L, L));
    add(mki(L, 32'h44, L, 0, H, 32'h40, L, L, L),       mko(L, 0, L, 0, H, L, L));
    add(mki(L, 32'h44, L, 0, H, 32'h40, L, L, L),       zero_out());
    add(mki(L, 32'h44, L, 0, H, 32'h40, L, L, L),       mko(L, 0, H, 32'h40, L, H, L));
    add(idle(),                                         zero_out());
    for (int i = 0; i < stim_q.size(); i++) begin
      drive(stim_q[i], plan_q[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stall_priority[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_halt_resume();
    out_t e, o;
    stim_q.delete(); plan_q.delete();
    add(mki(L, 32'h80, L, 0, H, 32'h40, L, H, L),       mko(L, 0, H, 32'h80, L, L, L));
    add(mki(L, 32'h84, L, 0, H, 32'h40, L, H, L),       mko(L, 0, H, 32'h80, L, L, L));
    add(mki(L, 32'h88, L, 0, H, 32'h40, L, H, L),       mko(L, 0, H, 32'h80, L, L, L));
    add(mki(L, 32'h8C, L, 0, L, 0, L, H, L),            mko(L, 0, H, 32'h80, L, H, H));
    add(mki(L, 32'h8C, H, 32'h500, L, 0, L, H, L),      mko(L, 0, H, 32'h80, L, H, H));
    add(mki(L, 32'h8C, L, 0, L, 0, L, L, H),            zero_out());
    add(idle(),                                         zero_out());
    // resume together with halt: one free cycle, then halt again
    add(mki(L, 32'h90, L, 0, L, 0, L, H, L),            mko(L, 0, H, 32'h90, L, L, L));
    add(mki(L, 32'h90, L, 0, L, 0, L, H, L),            mko(L, 0, H, 32'h90, L, H, H));
    add(mki(L, 32'h90, L, 0, L, 0, L, H, H),            zero_out());
    add(mki(L, 32'h94, L, 0, L, 0, L, H, L),            mko(L, 0, H, 32'h94, L, L, L));
    add(mki(L, 32'h98, L, 0, L, 0, L, H, L),            mko(L, 0, H, 32'h94, L, H, H));
    add(mki(L, 32'h98, L, 0, L, 0, L, L, H),            zero_out());
    // jump during drain moves the halt PC; dropping halt returns to RUN
    add(mki(L, 32'hA0, L, 0, H, 32'h40, L, H, L),       mko(L, 0, H, 32'hA0, L, L, L));
    add(mki(L, 32'hA0, H, 32'h600, H, 32'h40, L, H, L), mko(H, 32'h600, L, 0, L, L, L));
    add(mki(L, 32'hA4, L, 0, H, 32'h40, L, H, L),       mko(L, 0, H, 32'h600, L, L, L));
    add(mki(L, 32'hA4, L, 0, H, 32'h40, L, L, L),       zero_out());
    add(idle(),                                         zero_out());
    for (int i = 0; i < stim_q.size(); i++) begin
      drive(stim_q[i], plan_q[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL halt_resume[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_drain_timeout();
    out_t e, o;
    stim_q.delete(); plan_q.delete();
    add(mki(L, 32'hC0, L, 0, H, 32'h40, L, H, L),       mko(L, 0, H, 32'hC0, L, L, L));
    for (int k = 0; k < 14; k++)
      add(mki(L, 32'hC4, L, 0, H, 32'h40, L, H, L),     mko(L, 0, H, 32'hC0, L, L, L));
    add(mki(L, 32'hC4, L, 0, H, 32'h40, L, H, L),       mko(L, 0, H, 32'hC0, L, H, H));
    add(mki(L, 32'hC4, L, 0, H, 32'h40, L, H, L),       mko(L, 0, H, 32'hC0, L, H, H));
    add(mki(H, 32'hC4, L, 0, H, 32'h40, L, H, L),       zero_out());
    add(idle(),                                         zero_out());
    add(mki(L, 32'h10, L, 0, L, 0, H, L, L),            mko(L, 0, H, 32'h10, L, H, L));
    add(idle(),                                         zero_out());
    for (int i = 0; i < stim_q.size(); i++) begin
      drive(stim_q[i], plan_q[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL drain_timeout[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_jump();
    test_back_to_back();
    test_stall_priority();
    test_halt_resume();
    test_drain_timeout();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
